mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared single-port 256x16 program/data memory.
- Arbitrates between the instruction-fetch port (read-only) and the data load/store port (read/write), and drives the memory's ce/rw/addr/reg_in.
- Captures the memory's registered reg_out (1-cycle read latency) and returns it to the winning requester with a one-cycle ack pulse.
- Sits between the CPU control unit and the memory; the memory's own clr input is not driven by this block.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared single-port program/data memory.
// The instruction-fetch port (read-only) and the data load/store port share one
// memory. Each access runs IDLE -> ACCESS -> RESP, with a one-cycle ack issued on
// the return to IDLE. Round-robin fairness is tracked by a single rr_last bit.
module mem_port_arbiter #(
   parameter int addr_width = 8,
   parameter int data_width = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  f_req,
   input  logic [addr_width-1:0] f_addr,
   output logic                  f_ack,
   output logic [data_width-1:0] f_rdata,
   input  logic                  d_req,
   input  logic                  d_rw,
   input  logic [addr_width-1:0] d_addr,
   input  logic [data_width-1:0] d_wdata,
   output logic                  d_ack,
   output logic [data_width-1:0] d_rdata,
   output logic                  mem_ce,
   output logic                  mem_rw,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wdata,
   input  logic [data_width-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   state_t r_state;
   logic   r_owner;
   logic   r_rr_last;

   logic   w_f_eff;
   logic   w_d_eff;
   logic   w_grant_any;
   logic   w_grant_data;

   // Effective requests: a port is deaf during its own ack cycle, so a requester
   // that has not yet dropped req does not get a duplicate grant.
   always_comb begin
      w_f_eff      = f_req & ~f_ack;
      w_d_eff      = d_req & ~d_ack;
      w_grant_any  = w_f_eff | w_d_eff;
      // Data wins when it is alone, or on a conflict when fetch went last.
      w_grant_data = w_d_eff & (~w_f_eff | (r_rr_last == OWNER_FETCH));
   end

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state   <= S_IDLE;
         r_owner   <= OWNER_FETCH;
         r_rr_last <= OWNER_DATA;
         mem_ce    <= 1'b0;
         mem_rw    <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         busy      <= 1'b0;
      end else begin
         // Acks are single-cycle pulses.
         f_ack <= 1'b0;
         d_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               mem_ce <= 1'b0;
               if (w_grant_any) begin
                  r_owner   <= w_grant_data;
                  r_rr_last <= w_grant_data;
                  mem_ce    <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= S_ACCESS;
                  if (w_grant_data) begin
                     mem_rw    <= d_rw;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     // Fetch is read-only; the write-data register is left as is.
                     mem_rw   <= 1'b1;
                     mem_addr <= f_addr;
                  end
               end
            end
            S_ACCESS: begin
               // The memory has sampled ce this cycle; its reg_out is valid in RESP.
               mem_ce  <= 1'b0;
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (r_owner == OWNER_FETCH) begin
                  f_ack   <= 1'b1;
                  f_rdata <= mem_rdata;
               end else begin
                  d_ack <= 1'b1;
                  // Writes leave the read-data register untouched.
                  if (mem_rw) begin
                     d_rdata <= mem_rdata;
                  end
               end
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               mem_ce  <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of per-cycle vectors, followed by
// hand-written sequences for conflicts, a mid-access reset and request stability.
// A 256x16 memory model with registered read output sits on the memory side.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        clr;
   logic        f_req;
   logic [7:0]  f_addr;
   logic        f_ack;
   logic [15:0] f_rdata;
   logic        d_req;
   logic        d_rw;
   logic [7:0]  d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        mem_ce;
   logic        mem_rw;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] r_mem [0:255];

   mem_port_arbiter #(.addr_width(8), .data_width(16)) dut (
      .clk      (clk),
      .clr      (clr),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_ack    (f_ack),
      .f_rdata  (f_rdata),
      .d_req    (d_req),
      .d_rw     (d_rw),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .mem_ce   (mem_ce),
      .mem_rw   (mem_rw),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Single-port memory: registered read, write on ce with rw=0.
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_rw) mem_rdata <= r_mem[mem_addr];
         else        r_mem[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      logic        clr;
      logic        f_req;
      logic [7:0]  f_addr;
      logic        d_req;
      logic        d_rw;
      logic [7:0]  d_addr;
      logic [15:0] d_wdata;
      logic        e_f_ack;
      logic        e_d_ack;
      logic [15:0] e_f_rdata;
      logic [15:0] e_d_rdata;
      logic        e_ce;
      logic        e_rw;
      logic [7:0]  e_addr;
      logic [15:0] e_wdata;
      logic        e_busy;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mkv(
      input logic c, input logic fr, input logic [7:0] fa,
      input logic dr, input logic drw, input logic [7:0] da, input logic [15:0] dw,
      input logic ef, input logic ed, input logic [15:0] efr, input logic [15:0] edr,
      input logic ece, input logic erw, input logic [7:0] ea, input logic [15:0] ew,
      input logic eb);
      vec_t v;
      v.clr = c; v.f_req = fr; v.f_addr = fa;
      v.d_req = dr; v.d_rw = drw; v.d_addr = da; v.d_wdata = dw;
      v.e_f_ack = ef; v.e_d_ack = ed; v.e_f_rdata = efr; v.e_d_rdata = edr;
      v.e_ce = ece; v.e_rw = erw; v.e_addr = ea; v.e_wdata = ew; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic c, input logic fr, input logic [7:0] fa,
                         input logic dr, input logic drw, input logic [7:0] da,
                         input logic [15:0] dw);
      clr = c; f_req = fr; f_addr = fa;
      d_req = dr; d_rw = drw; d_addr = da; d_wdata = dw;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) r_mem[i] = 16'h0000;
      r_mem[3] = 16'h3803;
      r_mem[5] = 16'h5A5A;
      mem_rdata = 16'h0000;
      set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000);

      // clr  freq faddr dreq drw daddr  dwdata    | fack dack frdata    drdata    ce rw addr  wdata     busy
      vecs[0]  = mkv(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 8'h00, 16'h0000, 0);
      vecs[1]  = mkv(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 8'h00, 16'h0000, 0);
      vecs[2]  = mkv(1, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 8'h00, 16'h0000, 0);
      // single fetch from 3
      vecs[3]  = mkv(1, 1, 8'h03, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h03, 16'h0000, 1);
      vecs[4]  = mkv(1, 1, 8'h03, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 8'h03, 16'h0000, 1);
      vecs[5]  = mkv(1, 1, 8'h03, 0, 1, 8'h00, 16'h0000, 1, 0, 16'h3803, 16'h0000, 0, 1, 8'h03, 16'h0000, 0);
      vecs[6]  = mkv(1, 1, 8'h03, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h3803, 16'h0000, 0, 1, 8'h03, 16'h0000, 0);
      vecs[7]  = mkv(1, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h3803, 16'h0000, 0, 1, 8'h03, 16'h0000, 0);
      // data write BEEF to 255
      vecs[8]  = mkv(1, 0, 8'h00, 1, 0, 8'hFF, 16'hBEEF, 0, 0, 16'h3803, 16'h0000, 1, 0, 8'hFF, 16'hBEEF, 1);
      vecs[9]  = mkv(1, 0, 8'h00, 1, 0, 8'hFF, 16'hBEEF, 0, 0, 16'h3803, 16'h0000, 0, 0, 8'hFF, 16'hBEEF, 1);
      vecs[10] = mkv(1, 0, 8'h00, 1, 0, 8'hFF, 16'hBEEF, 0, 1, 16'h3803, 16'h0000, 0, 0, 8'hFF, 16'hBEEF, 0);
      vecs[11] = mkv(1, 0, 8'h00, 0, 0, 8'hFF, 16'hBEEF, 0, 0, 16'h3803, 16'h0000, 0, 0, 8'hFF, 16'hBEEF, 0);
      // data read back from 255
      vecs[12] = mkv(1, 0, 8'h00, 1, 1, 8'hFF, 16'h0000, 0, 0, 16'h3803, 16'h0000, 1, 1, 8'hFF, 16'h0000, 1);
      vecs[13] = mkv(1, 0, 8'h00, 1, 1, 8'hFF, 16'h0000, 0, 0, 16'h3803, 16'h0000, 0, 1, 8'hFF, 16'h0000, 1);
      vecs[14] = mkv(1, 0, 8'h00, 1, 1, 8'hFF, 16'h0000, 0, 1, 16'h3803, 16'hBEEF, 0, 1, 8'hFF, 16'h0000, 0);
      vecs[15] = mkv(1, 0, 8'h00, 0, 1, 8'hFF, 16'h0000, 0, 0, 16'h3803, 16'hBEEF, 0, 1, 8'hFF, 16'h0000, 0);

      #2;
      for (int i = 0; i < 16; i++) begin
         set_in(vecs[i].clr, vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req,
                vecs[i].d_rw, vecs[i].d_addr, vecs[i].d_wdata);
         tick();
         chk($sformatf("v%0d_f_ack", i),   {15'd0, f_ack},  {15'd0, vecs[i].e_f_ack});
         chk($sformatf("v%0d_d_ack", i),   {15'd0, d_ack},  {15'd0, vecs[i].e_d_ack});
         chk($sformatf("v%0d_f_rdata", i), f_rdata,         vecs[i].e_f_rdata);
         chk($sformatf("v%0d_d_rdata", i), d_rdata,         vecs[i].e_d_rdata);
         chk($sformatf("v%0d_mem_ce", i),  {15'd0, mem_ce}, {15'd0, vecs[i].e_ce});
         chk($sformatf("v%0d_mem_rw", i),  {15'd0, mem_rw}, {15'd0, vecs[i].e_rw});
         chk($sformatf("v%0d_mem_addr", i), {8'd0, mem_addr}, {8'd0, vecs[i].e_addr});
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata,     vecs[i].e_wdata);
         chk($sformatf("v%0d_busy", i),    {15'd0, busy},   {15'd0, vecs[i].e_busy});
         $display("[TB] vec %0d: f_ack=%0d d_ack=%0d ce=%0d addr=%h busy=%0d",
                  i, f_ack, d_ack, mem_ce, mem_addr, busy);
      end

      // Conflict right after reset: fetch wins first, then strict alternation.
      set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      tick();
      set_in(1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 8'hFF, 16'h0000);
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("alt%0d_f_ack", i), {15'd0, f_ack}, {15'd0, (i % 6) == 3});
         chk($sformatf("alt%0d_d_ack", i), {15'd0, d_ack}, {15'd0, (i % 6) == 0});
         if ((i % 6) == 3) chk($sformatf("alt%0d_f_rdata", i), f_rdata, 16'h3803);
         if ((i % 6) == 0) chk($sformatf("alt%0d_d_rdata", i), d_rdata, 16'hBEEF);
         $display("[TB] alt cycle %0d: f_ack=%0d d_ack=%0d", i, f_ack, d_ack);
      end
      set_in(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 8'hFF, 16'h0000);
      tick();
      chk("alt_idle_ce", {15'd0, mem_ce}, 16'd0);

      // Reset while the fetch is in RESP: the ack is abandoned.
      set_in(1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      tick();
      chk("rst_in_resp_busy", {15'd0, busy}, 16'd1);
      set_in(1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      chk("rst_f_ack", {15'd0, f_ack}, 16'd0);
      chk("rst_f_rdata", f_rdata, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_ce", {15'd0, mem_ce}, 16'd0);
      set_in(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      chk("rst_post_f_ack", {15'd0, f_ack}, 16'd0);
      $display("[TB] mid-reset: f_ack=%0d f_rdata=%h", f_ack, f_rdata);
      // Resubmit completes normally in three cycles.
      set_in(1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      tick();
      chk("resub_noack_early", {15'd0, f_ack}, 16'd0);
      tick();
      chk("resub_f_ack", {15'd0, f_ack}, 16'd1);
      chk("resub_f_rdata", f_rdata, 16'h3803);
      $display("[TB] resubmit: f_ack=%0d f_rdata=%h", f_ack, f_rdata);
      set_in(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();

      // Address changed during ACCESS must not reach the memory.
      set_in(1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      chk("stab_access_addr", {8'd0, mem_addr}, 16'h0003);
      f_addr = 8'h05;
      tick();
      chk("stab_resp_addr", {8'd0, mem_addr}, 16'h0003);
      tick();
      chk("stab_f_ack", {15'd0, f_ack}, 16'd1);
      chk("stab_f_rdata", f_rdata, 16'h3803);
      $display("[TB] stability: mem_addr=%h f_rdata=%h", mem_addr, f_rdata);
      set_in(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00, 16'h0000);
      tick();
      chk("stab_ack_clear", {15'd0, f_ack}, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
